// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned 16x16 multiply / 16/16 divide that borrows the shared core ALU once per iteration.
// Latency WIDTH+1 cycles from accepted start to done, plus one cycle per withheld grant; start is ignored while busy.
module alu_muldiv_seq #(
    parameter int         WIDTH  = 16,
    parameter logic [3:0] OP_ADD = 4'h4,
    parameter logic [3:0] OP_SUB = 4'h5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_agg,
    input  logic             alu_c
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // multiply: accumulator, divide: remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiply: multiplier/product low, divide: quotient
    logic [WIDTH-1:0] m_q, m_d;         // multiplicand or divisor
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   div_s;
    logic             take;
    logic             last_iter;

    assign div_s     = {acc_q, lo_q[WIDTH-1]};
    // Shifted-out remainder bit means s already exceeds any 16-bit divisor.
    assign take      = div_s[WIDTH] | ~alu_c;
    assign last_iter = (count_q == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            count_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            count_q  <= count_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        m_d      = m_q;
        count_d  = count_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op_div;
                    if (op_div && (b_in == '0)) begin
                        state_d  = FIN;
                        res_lo_d = '1;
                        res_hi_d = a_in;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = ITER;
                        acc_d   = '0;
                        lo_d    = op_div ? a_in : b_in;
                        m_d     = op_div ? b_in : a_in;
                        count_d = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            ITER: begin
                if (alu_gnt) begin
                    count_d = count_q + CW'(1);
                    if (is_div_q) begin
                        acc_d = take ? alu_agg : div_s[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], take};
                    end else begin
                        acc_d = {alu_c, alu_agg[WIDTH-1:1]};
                        lo_d  = {alu_agg[0], lo_q[WIDTH-1:1]};
                    end
                    if (last_iter) begin
                        state_d  = FIN;
                        res_lo_d = lo_d;
                        res_hi_d = acc_d;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        alu_req       = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_operation = OP_ADD;
        case (state_q)
            ITER: begin
                busy    = 1'b1;
                alu_req = 1'b1;
                if (is_div_q) begin
                    alu_a         = div_s[WIDTH-1:0];
                    alu_b         = m_q;
                    alu_operation = OP_SUB;
                end else begin
                    alu_a = acc_q;
                    alu_b = lo_q[0] ? m_q : '0;
                end
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural shared ALU.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op_div;
    logic [15:0] a_in, b_in;
    logic        busy, done, div_by_zero, alu_req, alu_gnt, alu_c;
    logic [15:0] result_lo, result_hi, alu_a, alu_b, alu_agg;
    logic [3:0]  alu_operation;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_div(op_div),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
        .alu_operation(alu_operation), .alu_agg(alu_agg), .alu_c(alu_c)
    );

    // Shared core ALU: ADD gives carry-out, SUB gives borrow.
    always_comb begin
        if (alu_operation == 4'h5) {alu_c, alu_agg} = {1'b0, alu_a} - {1'b0, alu_b};
        else                       {alu_c, alu_agg} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    always @(negedge clk) begin
        if (alu_req) req_cnt = req_cnt + 1;
        if (busy && done) overlap_cnt = overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic div, input logic [15:0] a, input logic [15:0] b,
                         input logic alt, input logic inject, input int exp_lat,
                         input logic [31:0] exp_res, input logic exp_dbz);
        int          lat;
        logic        stalled;
        logic [35:0] prev;
        start   = 1'b1;
        op_div  = div;
        a_in    = a;
        b_in    = b;
        alu_gnt = 1'b1;
        step();
        start   = 1'b0;
        lat     = 1;
        alu_gnt = alt ? 1'b0 : 1'b1;
        while (!done && lat < 100) begin
            stalled = busy && !alu_gnt;
            prev    = {alu_a, alu_b, alu_operation};
            if (inject && lat == 5) begin
                check({tag, "_busy_mid"}, 40'(busy), 40'd1);
                start  = 1'b1;
                op_div = 1'b1;
                a_in   = 16'h1111;
                b_in   = 16'h2222;
            end
            step();
            start = 1'b0;
            lat++;
            if (stalled) check({tag, "_stall_stable"}, 40'({alu_a, alu_b, alu_operation}), 40'(prev));
            alu_gnt = alt ? (lat % 2 == 0) : 1'b1;
        end
        check({tag, "_lat"}, 40'(lat), 40'(exp_lat));
        check({tag, "_res"}, 40'({result_hi, result_lo}), 40'(exp_res));
        check({tag, "_dbz"}, 40'(div_by_zero), 40'(exp_dbz));
        check({tag, "_busy_at_done"}, 40'(busy), 40'd0);
        step();
        check({tag, "_done_pulse"}, 40'(done), 40'd0);
        check({tag, "_hold"}, 40'({result_hi, result_lo}), 40'(exp_res));
    endtask

    initial begin
        int req_before;
        reset_n = 1'b0;
        start   = 1'b0;
        op_div  = 1'b0;
        a_in    = '0;
        b_in    = '0;
        alu_gnt = 1'b0;
        #12;
        check("rst_ctrl", 40'({busy, done, div_by_zero, alu_req}), 40'd0);
        check("rst_res", 40'({result_hi, result_lo}), 40'd0);
        check("rst_alu_ops", 40'({alu_a, alu_b}), 40'd0);
        check("rst_alu_op", 40'(alu_operation), 40'h4);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        do_op("mul_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17, 32'hFFFE_0001, 1'b0);
        do_op("div_1000_7", 1'b1, 16'd1000, 16'd7, 1'b0, 1'b0, 17, {16'h0006, 16'h008E}, 1'b0);
        do_op("div_ffff_8000", 1'b1, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 17, {16'h7FFF, 16'h0001}, 1'b0);

        req_before = req_cnt;
        do_op("div_zero", 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1, {16'h1234, 16'hFFFF}, 1'b1);
        check("div_zero_no_req", 40'(req_cnt - req_before), 40'd0);

        do_op("mul_stall", 1'b0, 16'd300, 16'd200, 1'b1, 1'b1, 33, 32'h0000_EA60, 1'b0);

        // Abort a divide after eight granted iterations.
        start   = 1'b1;
        op_div  = 1'b1;
        a_in    = 16'hFFFF;
        b_in    = 16'h0003;
        alu_gnt = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("abort_busy_before", 40'(busy), 40'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ctrl", 40'({busy, done, div_by_zero, alu_req}), 40'd0);
        check("abort_res", 40'({result_hi, result_lo}), 40'd0);
        step();
        check("abort_no_done", 40'(done), 40'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        do_op("mul_6_7", 1'b0, 16'd6, 16'd7, 1'b0, 1'b0, 17, 32'h0000_002A, 1'b0);
        check("busy_done_overlap", 40'(overlap_cnt), 40'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
